// File: rtl/frame_timing_pkg.sv
// Shared frame timing constants, FSM encoding and SFN width for the frame head tx/rx pair.
// Pure declarations: no latency, no backpressure.
package frame_timing_pkg;

    localparam int SFN_W = 10;
    localparam int CNT_W = 23;

    localparam int unsigned TICKS_10MS_122M88 = 32'd1228800;
    localparam int unsigned TICKS_10MS_245M76 = 32'd2457600;
    localparam int unsigned TICKS_10MS_491M52 = 32'd4915200;
    localparam int unsigned TICKS_80MS_122M88 = 32'd8 * TICKS_10MS_122M88;
    localparam int unsigned TICKS_80MS_245M76 = 32'd8 * TICKS_10MS_245M76;
    localparam int unsigned TICKS_80MS_491M52 = 32'd8 * TICKS_10MS_491M52;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_PPS = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

    // A nonzero test length shortens the frame so simulations stay small.
    function automatic int unsigned frame_ticks(input int clk_set, input int unsigned test_len);
        if (test_len != 0) begin
            return test_len;
        end
        case (clk_set)
            1:       return TICKS_10MS_122M88;
            2:       return TICKS_10MS_245M76;
            default: return TICKS_10MS_491M52;
        endcase
    endfunction

endpackage

// File: rtl/frame_pulse_stretch.sv
// Re-triggerable pulse stretcher: output high PULSE_W cycles starting the cycle after trigger.
// No backpressure; clear forces the output low combinationally and empties the count.
module frame_pulse_stretch #(
    parameter int PULSE_W = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic trigger,
    input  logic clear,
    output logic pulse
);

    logic [3:0] remain;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            remain <= '0;
        end else if (clear) begin
            remain <= '0;
        end else if (trigger) begin
            remain <= 4'(PULSE_W);
        end else if (remain != '0) begin
            remain <= remain - 4'd1;
        end
    end

    assign pulse = (remain != '0) && !clear;

endmodule

// File: rtl/sys_frame_head_tx.sv
// Master frame head generator: 10 ms / 80 ms pulses one cycle after each cnt==0 in RUN, optional 1PPS alignment.
// No backpressure: outputs are free-running; dropping i_enable truncates pulses in the same cycle.
module sys_frame_head_tx
    import frame_timing_pkg::*;
#(
    parameter int          CLK_SET        = 1,
    parameter int          PULSE_W        = 4,
    parameter int unsigned TEST_FRAME_LEN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_sync_mode,
    input  logic             i_pps,
    input  logic [SFN_W-1:0] i_sfn_init,
    input  logic             i_sfn_load,
    output logic             o_frame_10ms,
    output logic             o_frame_80ms,
    output logic [SFN_W-1:0] o_sfn,
    output logic [CNT_W-1:0] o_cnt_10ms,
    output logic [1:0]       o_state,
    output logic             o_locked,
    output logic [7:0]       o_pps_err_num
);

    localparam int unsigned      FRAME_LEN = frame_ticks(CLK_SET, TEST_FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_LEN - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [SFN_W-1:0] sfn;
    logic             load_pending;
    logic             locked;
    logic [7:0]       err_num;
    logic             pps_d1;
    logic             pps_d2;
    logic             pps_d3;
    logic             pps_p;
    logic             start;
    logic             running;
    logic             pps_chk;
    logic             pps_miss;
    logic             wrap;
    logic             head;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pps_d1 <= 1'b0;
            pps_d2 <= 1'b0;
            pps_d3 <= 1'b0;
        end else begin
            pps_d1 <= i_pps;
            pps_d2 <= pps_d1;
            pps_d3 <= pps_d2;
        end
    end

    assign pps_p = pps_d2 & ~pps_d3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!i_enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     state_nxt = i_sync_mode ? ST_WAIT_PPS : ST_RUN;
                ST_WAIT_PPS: if (pps_p) state_nxt = ST_RUN;
                ST_RUN:      state_nxt = ST_RUN;
                default:     state_nxt = ST_IDLE;
            endcase
        end
    end

    assign start    = i_enable && (((state == ST_IDLE) && !i_sync_mode) ||
                                   ((state == ST_WAIT_PPS) && pps_p));
    assign running  = i_enable && (state == ST_RUN);
    assign pps_chk  = running && i_sync_mode && pps_p;
    // A PPS landing on the last count is one cycle early, so it is a miss too.
    assign pps_miss = pps_chk && (cnt != '0);
    assign wrap     = running && ((cnt == CNT_LAST) || pps_miss);
    assign head     = (state == ST_RUN) && (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            sfn          <= '0;
            load_pending <= 1'b0;
            locked       <= 1'b0;
            err_num      <= '0;
        end else begin
            if (start) begin
                cnt <= '0;
                sfn <= i_sfn_init;
            end else if (wrap) begin
                cnt <= '0;
                sfn <= (load_pending || i_sfn_load) ? i_sfn_init : sfn + 10'd1;
            end else if (running) begin
                cnt <= cnt + 23'd1;
            end

            if (wrap) begin
                load_pending <= 1'b0;
            end else if (i_enable && i_sfn_load) begin
                load_pending <= 1'b1;
            end

            if (i_enable && (state == ST_WAIT_PPS) && pps_p) begin
                locked <= 1'b1;
            end else if (running && !i_sync_mode) begin
                locked <= 1'b0;
            end else if (pps_chk) begin
                locked <= !pps_miss;
            end

            if (pps_miss && (err_num != 8'hFF)) begin
                err_num <= err_num + 8'd1;
            end
        end
    end

    frame_pulse_stretch #(.PULSE_W(PULSE_W)) u_stretch_10ms (
        .clk     (clk),
        .rst     (rst),
        .trigger (head),
        .clear   (!i_enable),
        .pulse   (o_frame_10ms)
    );

    frame_pulse_stretch #(.PULSE_W(PULSE_W)) u_stretch_80ms (
        .clk     (clk),
        .rst     (rst),
        .trigger (head && (sfn[2:0] == 3'd0)),
        .clear   (!i_enable),
        .pulse   (o_frame_80ms)
    );

    assign o_sfn         = sfn;
    assign o_cnt_10ms    = cnt;
    assign o_state       = state;
    assign o_locked      = locked;
    assign o_pps_err_num = err_num;

endmodule

// File: tb/tb_sys_frame_head_tx.sv
// Self-checking bench for sys_frame_head_tx with an 80-cycle test frame and 4-cycle pulses.
module tb_sys_frame_head_tx;

    localparam int P  = 80;
    localparam int PW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_enable = 1'b0;
    logic        i_sync_mode = 1'b0;
    logic        i_pps = 1'b0;
    logic [9:0]  i_sfn_init = '0;
    logic        i_sfn_load = 1'b0;
    logic        o_frame_10ms;
    logic        o_frame_80ms;
    logic [9:0]  o_sfn;
    logic [22:0] o_cnt_10ms;
    logic [1:0]  o_state;
    logic        o_locked;
    logic [7:0]  o_pps_err_num;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_err = 0;
    int init_pps = 0;

    always #5 clk = ~clk;

    sys_frame_head_tx #(.CLK_SET(1), .PULSE_W(PW), .TEST_FRAME_LEN(P)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_enable      (i_enable),
        .i_sync_mode   (i_sync_mode),
        .i_pps         (i_pps),
        .i_sfn_init    (i_sfn_init),
        .i_sfn_load    (i_sfn_load),
        .o_frame_10ms  (o_frame_10ms),
        .o_frame_80ms  (o_frame_80ms),
        .o_sfn         (o_sfn),
        .o_cnt_10ms    (o_cnt_10ms),
        .o_state       (o_state),
        .o_locked      (o_locked),
        .o_pps_err_num (o_pps_err_num)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int load_sfn(input int a, input int b, input int f);
        return (f == 0) ? a : (b + f - 1) % 1024;
    endfunction

    task automatic go_idle();
        i_enable = 1'b0; i_pps = 1'b0; i_sfn_load = 1'b0;
        tick();
        n_tests++;
        if (o_state !== 2'd0) begin
            n_fail++; $display("FAIL go_idle state got %0d exp 0", o_state);
        end
        tick(); tick(); tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        n_tests++;
        if ({o_frame_10ms, o_frame_80ms, o_sfn, o_cnt_10ms, o_state, o_locked, o_pps_err_num} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b exp all zero",
                     {o_frame_10ms, o_frame_80ms, o_sfn, o_cnt_10ms, o_state, o_locked, o_pps_err_num});
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if (o_state !== 2'd0 || o_cnt_10ms !== '0) begin
            n_fail++; $display("FAIL reset_idle state %0d cnt %0d exp 0 0", o_state, o_cnt_10ms);
        end
    endtask

    task automatic test_free_run(input int init, input int frames, input bit noisy_pps);
        go_idle();
        i_sync_mode = 1'b0; i_sfn_init = 10'(init); i_enable = 1'b1;
        for (int k = 1; k <= frames * P + 1; k++) begin
            int c, sfn_e, fh;
            bit hi10, hi80;
            tick();
            c     = (k - 1) % P;
            sfn_e = (init + (k - 1) / P) % 1024;
            hi10  = (k >= 2) && (((k - 2) % P) < PW);
            fh    = (k >= 2) ? (k - 2) / P : 0;
            hi80  = hi10 && ((((init + fh) % 1024) % 8) == 0);
            n_tests++;
            if (o_state !== 2'd2 || o_cnt_10ms !== 23'(c) || o_sfn !== 10'(sfn_e)) begin
                n_fail++;
                $display("FAIL free_cnt k=%0d state %0d cnt %0d sfn %0d exp 2 %0d %0d",
                         k, o_state, o_cnt_10ms, o_sfn, c, sfn_e);
            end
            n_tests++;
            if (o_frame_10ms !== hi10 || o_frame_80ms !== hi80) begin
                n_fail++;
                $display("FAIL free_pulse k=%0d 10ms %b 80ms %b exp %b %b", k, o_frame_10ms, o_frame_80ms, hi10, hi80);
            end
            n_tests++;
            if (o_locked !== 1'b0 || o_pps_err_num !== 8'(exp_err)) begin
                n_fail++;
                $display("FAIL free_pps k=%0d locked %b err %0d exp 0 %0d", k, o_locked, o_pps_err_num, exp_err);
            end
            if (noisy_pps) i_pps = 1'($urandom_range(0, 1));
        end
        go_idle();
    endtask

    task automatic test_sfn_load(input int a, input int pos, input int b);
        go_idle();
        i_sync_mode = 1'b0; i_sfn_init = 10'(a); i_enable = 1'b1;
        for (int k = 1; k <= 6 * P + 1; k++) begin
            int sfn_e, fh;
            bit hi10, hi80;
            tick();
            sfn_e = load_sfn(a, b, (k - 1) / P);
            hi10  = (k >= 2) && (((k - 2) % P) < PW);
            fh    = (k >= 2) ? (k - 2) / P : 0;
            hi80  = hi10 && ((load_sfn(a, b, fh) % 8) == 0);
            n_tests++;
            if (o_sfn !== 10'(sfn_e) || o_frame_80ms !== hi80 || o_frame_10ms !== hi10) begin
                n_fail++;
                $display("FAIL sfn_load k=%0d sfn %0d 10ms %b 80ms %b exp %0d %b %b",
                         k, o_sfn, o_frame_10ms, o_frame_80ms, sfn_e, hi10, hi80);
            end
            i_sfn_load = (k == pos + 1);
            if (k >= pos + 1) i_sfn_init = 10'(b);
        end
        go_idle();
    endtask

    task automatic test_disable();
        int init;
        init = 8 * $urandom_range(0, 127);
        go_idle();
        i_sync_mode = 1'b0; i_sfn_init = 10'(init); i_enable = 1'b1;
        tick(); tick(); tick();
        n_tests++;
        if (o_frame_10ms !== 1'b1 || o_frame_80ms !== 1'b1) begin
            n_fail++; $display("FAIL dis_pre 10ms %b 80ms %b exp 1 1", o_frame_10ms, o_frame_80ms);
        end
        i_enable = 1'b0;
        #1;
        n_tests++;
        if (o_frame_10ms !== 1'b0 || o_frame_80ms !== 1'b0) begin
            n_fail++; $display("FAIL dis_same_cycle 10ms %b 80ms %b exp 0 0", o_frame_10ms, o_frame_80ms);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++;
            if (o_state !== 2'd0 || o_cnt_10ms !== 23'd2 || o_sfn !== 10'(init) ||
                o_frame_10ms !== 1'b0 || o_frame_80ms !== 1'b0) begin
                n_fail++;
                $display("FAIL dis_hold state %0d cnt %0d sfn %0d pulses %b%b exp 0 2 %0d 00",
                         o_state, o_cnt_10ms, o_sfn, o_frame_10ms, o_frame_80ms, init);
            end
        end
    endtask

    task automatic test_pps_align();
        int w;
        go_idle();
        init_pps = $urandom_range(0, 1023);
        i_sync_mode = 1'b1; i_sfn_init = 10'(init_pps); i_enable = 1'b1;
        w = $urandom_range(3, 12);
        for (int i = 0; i < w; i++) begin
            tick();
            n_tests++;
            if (o_state !== 2'd1 || o_frame_10ms !== 1'b0 || o_frame_80ms !== 1'b0) begin
                n_fail++; $display("FAIL wait_pps i=%0d state %0d pulses %b%b exp 1 00",
                                   i, o_state, o_frame_10ms, o_frame_80ms);
            end
        end
        i_pps = 1'b1;
        for (int i = 1; i <= 2; i++) begin
            tick();
            n_tests++;
            if (o_state !== 2'd1) begin
                n_fail++; $display("FAIL pps_latency e%0d state %0d exp 1", i, o_state);
            end
        end
        tick();
        n_tests++;
        if (o_state !== 2'd2 || o_cnt_10ms !== '0 || o_locked !== 1'b1 || o_sfn !== 10'(init_pps)) begin
            n_fail++; $display("FAIL pps_run state %0d cnt %0d locked %b sfn %0d exp 2 0 1 %0d",
                               o_state, o_cnt_10ms, o_locked, o_sfn, init_pps);
        end
        for (int i = 4; i <= 8; i++) begin
            bit hi;
            tick();
            if (i == 4) i_pps = 1'b0;
            hi = (i <= 7);
            n_tests++;
            if (o_frame_10ms !== hi || o_frame_80ms !== (hi && (init_pps % 8 == 0))) begin
                n_fail++; $display("FAIL pps_pulse e%0d 10ms %b 80ms %b exp %b", i, o_frame_10ms, o_frame_80ms, hi);
            end
        end
    endtask

    task automatic test_pps_misalign();
        int t;
        t = $urandom_range(10, 70);
        for (int i = 5; i < t - 2; i++) tick();
        i_pps = 1'b1;
        tick();
        i_pps = 1'b0;
        tick();
        n_tests++;
        if (o_cnt_10ms !== 23'(t) || o_locked !== 1'b1 || o_pps_err_num !== 8'(exp_err)) begin
            n_fail++; $display("FAIL mis_before cnt %0d locked %b err %0d exp %0d 1 %0d",
                               o_cnt_10ms, o_locked, o_pps_err_num, t, exp_err);
        end
        tick();
        exp_err++;
        n_tests++;
        if (o_cnt_10ms !== '0 || o_pps_err_num !== 8'(exp_err) || o_locked !== 1'b0 ||
            o_sfn !== 10'((init_pps + 1) % 1024)) begin
            n_fail++; $display("FAIL mis_after cnt %0d err %0d locked %b sfn %0d exp 0 %0d 0 %0d",
                               o_cnt_10ms, o_pps_err_num, o_locked, o_sfn, exp_err, (init_pps + 1) % 1024);
        end
        for (int i = 2; i <= 6; i++) begin
            tick();
            n_tests++;
            if (o_frame_10ms !== (i <= 5)) begin
                n_fail++; $display("FAIL mis_pulse e%0d got %b exp %b", i, o_frame_10ms, i <= 5);
            end
        end
        // PPS arriving on the last count of the frame
        for (int i = 6; i <= 77; i++) tick();
        i_pps = 1'b1;
        tick();
        i_pps = 1'b0;
        tick();
        n_tests++;
        if (o_cnt_10ms !== 23'(P - 1)) begin
            n_fail++; $display("FAIL wrap_pps_pre cnt %0d exp %0d", o_cnt_10ms, P - 1);
        end
        tick();
        exp_err++;
        n_tests++;
        if (o_cnt_10ms !== '0 || o_pps_err_num !== 8'(exp_err) || o_locked !== 1'b0 ||
            o_sfn !== 10'((init_pps + 2) % 1024)) begin
            n_fail++; $display("FAIL wrap_pps cnt %0d err %0d locked %b sfn %0d exp 0 %0d 0 %0d",
                               o_cnt_10ms, o_pps_err_num, o_locked, o_sfn, exp_err, (init_pps + 2) % 1024);
        end
        // PPS arriving exactly on cnt==0 relocks
        for (int i = 1; i <= 78; i++) tick();
        i_pps = 1'b1;
        tick();
        i_pps = 1'b0;
        tick();
        tick();
        n_tests++;
        if (o_cnt_10ms !== 23'd1 || o_locked !== 1'b1 || o_pps_err_num !== 8'(exp_err) ||
            o_sfn !== 10'((init_pps + 3) % 1024)) begin
            n_fail++; $display("FAIL relock cnt %0d locked %b err %0d sfn %0d exp 1 1 %0d %0d",
                               o_cnt_10ms, o_locked, o_pps_err_num, o_sfn, exp_err, (init_pps + 3) % 1024);
        end
    endtask

    task automatic test_err_saturate();
        for (int i = 0; i < 260; i++) begin
            i_pps = 1'b1;
            tick();
            i_pps = 1'b0;
            for (int j = 0; j < 5; j++) tick();
        end
        tick(); tick(); tick();
        n_tests++;
        if (o_pps_err_num !== 8'd255 || o_locked !== 1'b0) begin
            n_fail++; $display("FAIL err_saturate err %0d locked %b exp 255 0", o_pps_err_num, o_locked);
        end
    endtask

    task automatic test_reset_async();
        tick();
        #3;
        rst = 1'b0;
        #1;
        n_tests++;
        if ({o_frame_10ms, o_frame_80ms, o_sfn, o_cnt_10ms, o_state, o_locked, o_pps_err_num} !== '0) begin
            n_fail++;
            $display("FAIL async_reset got %b exp all zero",
                     {o_frame_10ms, o_frame_80ms, o_sfn, o_cnt_10ms, o_state, o_locked, o_pps_err_num});
        end
        i_enable = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if (o_state !== 2'd0 || o_pps_err_num !== 8'd0) begin
            n_fail++; $display("FAIL post_reset state %0d err %0d exp 0 0", o_state, o_pps_err_num);
        end
    endtask

    initial begin
        test_reset();
        test_free_run(5, 4, 1'b0);
        test_free_run(1022, 4, 1'b0);
        test_free_run($urandom_range(0, 1023), 3, 1'b1);
        test_sfn_load($urandom_range(0, 1023), 30, 100);
        test_sfn_load($urandom_range(0, 1023), 79, $urandom_range(0, 1023));
        test_sfn_load($urandom_range(0, 1023), $urandom_range(0, 79), $urandom_range(0, 1023));
        test_disable();
        test_pps_align();
        test_pps_misalign();
        test_err_saturate();
        test_reset_async();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
